// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 write-only peripheral front end: pin sync, 16-bit frame shift, one-cycle write strobe.
// Optional macro SPI_ERR_CNT_EN adds frame_err pulse and saturating err_count ports.
module spi_frame_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       valid,
  output logic       read_write,
  output logic [6:0] addr,
  output logic [7:0] data
`ifdef SPI_ERR_CNT_EN
  ,
  output logic       frame_err,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  localparam int unsigned SETTLE = SYNC_STAGES + 1;
  localparam int unsigned SW     = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] sclk_ff, copi_ff, ncs_ff;
  logic                   sclk_hist, ncs_hist;
  logic [SW-1:0]          settle_cnt;
  logic                   settled;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  state_t      state, state_nxt;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        cnt_clr, shift_en, frame_end, frame_ok, commit;

  // Edges are masked until the chains hold real pin samples, so ncs held low
  // across reset release cannot masquerade as a fresh falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_ff    <= '0;
      copi_ff    <= '0;
      ncs_ff     <= '1;
      sclk_hist  <= 1'b0;
      ncs_hist   <= 1'b1;
      settle_cnt <= '0;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
      copi_ff   <= {copi_ff[SYNC_STAGES-2:0], copi};
      ncs_ff    <= {ncs_ff[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_ff[SYNC_STAGES-1];
      ncs_hist  <= ncs_ff[SYNC_STAGES-1];
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign settled   = (settle_cnt == SW'(SETTLE));
  assign sclk_rise = settled &  sclk_ff[SYNC_STAGES-1] & ~sclk_hist;
  assign ncs_fall  = settled & ~ncs_ff[SYNC_STAGES-1]  &  ncs_hist;
  assign ncs_rise  = settled &  ncs_ff[SYNC_STAGES-1]  & ~ncs_hist;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ncs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (ncs_rise)                           state_nxt = IDLE;
        else if (sclk_rise && bit_cnt == 5'd16) state_nxt = OVER;
      end
      OVER:    if (ncs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE:  cnt_clr = ncs_fall;
      SHIFT: begin
        frame_end = ncs_rise;
        shift_en  = sclk_rise & ~ncs_rise;
      end
      OVER:  frame_end = ncs_rise;
      default: ;
    endcase
  end

  // bit_cnt here is the pre-edge count, so an sclk edge coincident with ncs_rise never counts.
  assign frame_ok = (state == SHIFT) && (bit_cnt == 5'd16) && shift_reg[15]
                    && (shift_reg[14:8] <= MAX_ADDR);
  assign commit   = frame_end & frame_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      valid      <= 1'b0;
      read_write <= 1'b0;
      addr       <= '0;
      data       <= '0;
    end else begin
      valid <= commit;
      if (commit) begin
        read_write <= shift_reg[15];
        addr       <= shift_reg[14:8];
        data       <= shift_reg[7:0];
      end
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[14:0], copi_ff[SYNC_STAGES-1]};
        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

`ifdef SPI_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= frame_end & ~frame_ok;
      if (frame_end && !frame_ok && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
